// File: rtl/mod_accumulator.sv
// Registered modular accumulator: each enabled cycle adds iData to the running
// sum and applies a single conditional subtraction of iQ.
`ifndef BITWIDTH
`define BITWIDTH 8
`endif

module mod_accumulator (
  input  logic                 iClk,
  input  logic                 iRstN,
  input  logic                 iEn,
  input  logic                 iClr,
  input  logic [`BITWIDTH-1:0] iData,
  input  logic [`BITWIDTH-1:0] iQ,
  output logic [`BITWIDTH-1:0] oData
);

  localparam int W = `BITWIDTH;

  logic [W-1:0] r_acc;
  logic [W:0]   w_sum;
  logic         w_ge_q;
  logic [W-1:0] w_next;

  // The sum carries one extra bit so that acc + iData never wraps before the
  // comparison against iQ.
  always_comb begin
    w_sum  = {1'b0, r_acc} + {1'b0, iData};
    w_ge_q = (w_sum >= {1'b0, iQ});
    w_next = w_ge_q ? W'(w_sum - {1'b0, iQ}) : w_sum[W-1:0];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs from the same edge, regardless of block ordering.
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      r_acc <= '0;
    end else if (iClr) begin
      r_acc <= '0;
    end else if (iEn) begin
      r_acc <= w_next;
    end
  end

  assign oData = r_acc;

endmodule

// File: tb/tb_mod_accumulator.sv
// Self-checking bench for mod_accumulator: directed test-plan sequences plus
// randomized traffic, checked through an expected-value queue and a monitor.
`ifndef BITWIDTH
`define BITWIDTH 8
`endif

module tb_mod_accumulator;

  localparam int W    = `BITWIDTH;
  localparam int MASK = (1 << W) - 1;

  logic         iClk;
  logic         iRstN;
  logic         iEn;
  logic         iClr;
  logic [W-1:0] iData;
  logic [W-1:0] iQ;
  logic [W-1:0] oData;

  mod_accumulator dut (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iEn   (iEn),
    .iClr  (iClr),
    .iData (iData),
    .iQ    (iQ),
    .oData (oData)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    string        name;
    logic [W-1:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   model_acc = 0;

  // Value after k enabled additions of 10 modulo 13, indexed by k % 13.
  int seq13 [13] = '{0, 10, 7, 4, 1, 11, 8, 5, 2, 12, 9, 6, 3};

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Drive one cycle of inputs (called at a falling edge), advance the
  // reference model and queue the value oData must show after the next edge.
  // A non-negative ref_val overrides the model with a hand-derived constant.
  task automatic step(input logic rst_n, input logic en, input logic clr,
                      input int d, input int q, input string name,
                      input int ref_val = -1);
    exp_t e;
    int   s;
    iRstN = rst_n;
    iEn   = en;
    iClr  = clr;
    iData = W'(d);
    iQ    = W'(q);
    if (!rst_n || clr) begin
      model_acc = 0;
    end else if (en) begin
      s = model_acc + (d & MASK);
      if (s >= (q & MASK)) s = s - (q & MASK);
      model_acc = s & MASK;
    end
    e.name = name;
    e.val  = (ref_val >= 0) ? W'(ref_val) : W'(model_acc);
    exp_q.push_back(e);
    @(negedge iClk);
  endtask

  // Monitor: oData is a plain register, so one result is due after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge iClk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, oData, e.val);
      end
    end
  end

  initial begin
    int k;
    int q;
    iRstN = 1'b0;
    iEn   = 1'b1;
    iClr  = 1'b0;
    iData = W'(10);
    iQ    = W'(13);
    @(negedge iClk);

    // Reset held with enable active.
    step(0, 1, 0, 10, 13, "reset_hold", 0);
    step(0, 1, 0, 10, 13, "reset_hold", 0);

    // Releasing reset leaves oData at 0 until the next edge.
    iRstN = 1'b1;
    #1;
    check("reset_release", oData, W'(0));

    // 40-cycle modular sequence, then continue up to oData = 8.
    for (k = 1; k <= 45; k++) step(1, 1, 0, 10, 13, "mod_seq", seq13[k % 13]);

    // Clear held for 40 cycles with enable active.
    for (int i = 0; i < 40; i++) step(1, 1, 1, 10, 13, "clear_hold", 0);

    // Resume from 0: 10, 7, 4.
    for (k = 1; k <= 3; k++) step(1, 1, 0, 10, 13, "resume", seq13[k % 13]);

    // Enable dropped: hold at 4.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 10, 13, "en_hold", 4);

    // Re-assert: 1, 11, then on to acc = 3 and the sum == q boundary.
    for (k = 4; k <= 12; k++) step(1, 1, 0, 10, 13, "reenable", seq13[k % 13]);
    step(1, 1, 0, 10, 13, "sum_eq_q", 0);

    // Priority: reset with clear, clear alone, then a mid-run reset pulse.
    step(1, 1, 0, 10, 13, "pre_prio", 10);
    step(0, 1, 1, 10, 13, "prio_rst_clr", 0);
    step(1, 1, 1, 10, 13, "prio_clr", 0);
    step(1, 1, 0, 10, 13, "after_clr", 10);
    step(1, 1, 0, 10, 13, "after_clr", 7);
    step(0, 1, 0, 10, 13, "rst_pulse", 0);
    step(1, 1, 0, 10, 13, "after_rst", 10);

    // Wide sums: 254 + 254 = 508 needs the extra bit.
    step(1, 0, 1, 0, 255, "wide_clr", 0);
    for (k = 1; k <= 10; k++) step(1, 1, 0, 254, 255, "wide_sum", 255 - k);

    // Randomized traffic in segments, each with its own modulus; a few cycles
    // violate the precondition (iData >= iQ, iQ = 0) and follow the single
    // conditional-subtract rule.
    for (int seg = 0; seg < 8; seg++) begin
      q = (seg == 7) ? 0 : $urandom_range(MASK, 1);
      step(1, 0, 1, 0, q, "rnd_clr");
      for (int i = 0; i < 50; i++) begin
        int  d;
        logic rst_n, clr, en;
        rst_n = ($urandom_range(63, 0) != 0);
        clr   = ($urandom_range(15, 0) == 0);
        en    = ($urandom_range(3, 0) != 0);
        if (q == 0 || $urandom_range(15, 0) == 0) d = $urandom_range(MASK, 0);
        else d = $urandom_range(q - 1, 0);
        step(rst_n, en, clr, d, q, "rnd");
      end
    end

    // Drain the expected queue with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge iClk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mod_accumulator.md
Name: mod_accumulator

Overview:
- Registered modular accumulator: each enabled cycle adds iData to the running sum and reduces the result modulo iQ.
- Used as the accumulation stage in modular-arithmetic datapaths, such as NTT/RNS-style MAC chains.
- oData is the accumulator register itself, driven directly with no output logic.

Parameters:
- BITWIDTH, default 8, datapath width of iData, iQ and oData.
  - Supplied as the `BITWIDTH text macro.
  - The block defines it as 8 if it is not already defined (`ifndef guard).

Ports:
- iClk  input  1  clock; all state updates on the rising edge.
- iRstN  input  1  synchronous active-low reset.
- iEn  input  1  accumulate enable.
- iClr  input  1  synchronous clear of the accumulator.
- iData  input  BITWIDTH  addend, unsigned.
- iQ  input  BITWIDTH  modulus, unsigned.
- oData  output  BITWIDTH  accumulator value (registered).

Behaviour:
- One clock, iClk. Reset is synchronous and active-low (iRstN). Polarity and synchronicity are fixed.
- Single state register acc, BITWIDTH bits. oData = acc, combinationally with no further logic.
- Priority at each rising edge of iClk, highest first:
  - iRstN = 0: acc <= 0.
  - else iClr = 1: acc <= 0. Clear holds acc at 0 for as long as it is asserted, regardless of iEn.
  - else iEn = 1: acc <= modadd(acc, iData, iQ).
  - else: acc holds.
- modadd(a, b, q):
  - sum = a + b, computed at BITWIDTH+1 bits (no carry loss).
  - If sum >= q (compared at BITWIDTH+1 bits), result = sum - q; otherwise result = sum.
  - The result is truncated to BITWIDTH bits.
- Operating precondition, for correct modular results: 1 <= iQ, iData < iQ, and acc < iQ. The last condition is guaranteed after reset or clear if iQ is held constant.
- Out-of-precondition inputs (iData >= iQ, iQ = 0, or iQ reduced mid-run) are not an error. The single conditional subtraction above is still applied exactly as specified, and no further reduction is performed.
- Latency: the update is visible on oData one cycle after the enabling edge. Throughput is one accumulation per cycle.
- iQ and iData are sampled at the same edge as the update; no input registering.
- Reset mid-operation discards the accumulated value. After reset is released, accumulation restarts from 0 on the next enabled edge.
- Before the first reset, the register value is undefined.
- No overflow or status outputs.

Test Plan:
- Reset: hold iRstN = 0 with iEn = 1, iData = 10, iQ = 13 for 2 cycles -> oData = 0 throughout. Releasing reset does not change oData until the next edge.
- Modular sequence, iQ = 13, iData = 10, iEn = 1, iClr = 0, BITWIDTH = 8.
  - Successive oData: 10, 7, 4, 1, 11, 8, 5, 2, 12, 9, 6, 3, 0, 10 (period 13).
  - The full 40-cycle run must match this repeating sequence exactly.
- Clear: raise iClr = 1 mid-sequence (for example at oData = 8) with iEn = 1 -> oData = 0 at the next edge, stays 0 for all 40 cycles with clear held. Dropping iClr resumes 10, 7, ...
- Enable hold: from oData = 4, drop iEn for 3 cycles -> oData stays 4. Re-assert -> 1, 11.
- Boundary sums:
  - BITWIDTH = 8, iQ = 255, iData = 254: sequence 254, 253, 252, ... The 9-bit sum 508 must not wrap.
  - iQ = 13, acc = 3, iData = 10: sum equals q exactly -> 0.
- Priority: assert iRstN = 0 and iClr = 1 together, then iClr alone with iEn = 1 -> oData = 0 in both cases. A reset pulse mid-run returns oData to 0, then 10 on the next enabled edge.
